// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART transmit-port arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_MAX_LEN = 16;
  localparam int GRANT_W     = $clog2(DEF_NUM_REQ);
  localparam int BEAT_W      = $clog2(DEF_MAX_LEN + 1);

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first set request strictly after last_grant, wrapping.
module rr_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic               any,
  output logic [GW-1:0]      winner
);

  int idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of the UART TX write port.
// Optional watchdog release of a silent owner: define UART_ARB_WDOG_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_full,
  output logic                          wr_uart,
  output logic [DATA_W-1:0]             w_data,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
`ifdef UART_ARB_WDOG_EN
  output logic                          wdog_abort,
`endif
  output logic                          busy,
  output logic                          len_trunc
);

  localparam int GW = id_width(NUM_REQ);
  localparam int BW = $clog2(MAX_LEN + 1);

  arb_state_t        state, next_state;
  logic [GW-1:0]     last_grant, winner;
  logic [BW-1:0]     beat_cnt;
  logic              any;
  logic              owner_vld, owner_last;
  logic [DATA_W-1:0] owner_data;
  logic              locked, xfer, cap_hit, release_now, wdog_hit;

  rr_arb_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .any        (any),
    .winner     (winner)
  );

  always_comb begin
    owner_vld  = 1'b0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        owner_vld  = req_valid[i];
        owner_last = req_last[i];
        owner_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign locked      = (state == LOCKED);
  assign busy        = locked;
  assign xfer        = locked & owner_vld & ~tx_full;
  assign cap_hit     = (beat_cnt == BW'(MAX_LEN - 1));
  assign release_now = (xfer & (owner_last | cap_hit)) | wdog_hit;

`ifdef UART_ARB_WDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog_cnt;
  logic          idle_cyc;

  // A full UART is not the owner's fault, so stalls neither count nor clear.
  assign idle_cyc   = locked & ~owner_vld & ~tx_full;
  assign wdog_hit   = idle_cyc & (wdog_cnt == TW'(TIMEOUT - 1));
  assign wdog_abort = wdog_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (!locked || owner_vld || wdog_hit) begin
      wdog_cnt <= '0;
    end else if (idle_cyc) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    req_ready  = '0;
    wr_uart    = 1'b0;
    w_data     = '0;
    len_trunc  = 1'b0;
    case (state)
      IDLE: begin
        if (any) next_state = LOCKED;
      end
      LOCKED: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == GW'(i)) req_ready[i] = ~tx_full;
        end
        wr_uart   = xfer;
        w_data    = owner_data;
        len_trunc = xfer & ~owner_last & cap_hit;
        if (release_now) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && any) grant_id <= winner;
      if (release_now) begin
        last_grant <= grant_id;
        beat_cnt   <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random packet traffic against a queue-based reference.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ML = 16;
  localparam int TO = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_full;
  logic           wr_uart;
  logic [W-1:0]   w_data;
  logic [1:0]     grant_id;
  logic           busy;
  logic           len_trunc;
`ifdef UART_ARB_WDOG_EN
  logic           wdog_abort;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_LEN(ML), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .grant_id  (grant_id),
`ifdef UART_ARB_WDOG_EN
    .wdog_abort(wdog_abort),
`endif
    .busy      (busy),
    .len_trunc (len_trunc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-requester pending beats: {last, byte}
  logic [8:0] q [N][$];
  logic [N-1:0] en;
  logic txf;

  // Reference: owner -1 means nobody holds the port
  int m_owner, m_last, m_beats, m_idle;
  int lt_seen, wd_seen;

  int         lg_cyc[$];
  int         lg_req[$];
  logic [7:0] lg_dat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ent(input string tag, input int i, input int ec, input int er, input int ed);
    if (i < lg_req.size()) begin
      chk({tag, "_req"}, lg_req[i], er);
      chk({tag, "_dat"}, {24'd0, lg_dat[i]}, ed);
      if (ec >= 0) chk({tag, "_cyc"}, lg_cyc[i], ec);
    end else begin
      chk({tag, "_present"}, lg_req.size(), i + 1);
    end
  endtask

  task automatic push_pkt(input int r, input int len, input int base);
    for (int k = 0; k < len; k++) q[r].push_back({(k == len - 1), 8'(base + k)});
  endtask

  task automatic m_reset();
    m_owner = -1; m_last = N - 1; m_beats = 0; m_idle = 0;
  endtask

  task automatic clear_log();
    lg_cyc.delete(); lg_req.delete(); lg_dat.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = en[i] && (q[i].size() != 0);
      req_data[i*W +: W] = (q[i].size() != 0) ? q[i][0][7:0] : 8'h00;
      req_last[i]        = (q[i].size() != 0) ? q[i][0][8] : 1'b0;
    end
    tx_full = txf;
  endtask

  task automatic cycle();
    logic [N-1:0] e_rdy;
    logic [7:0]   e_dat;
    logic         xfer, e_lt, e_wd, rel;
    int           g;
    drive();
    @(negedge clk);
    e_rdy = '0; e_dat = 8'h00; xfer = 1'b0; e_lt = 1'b0; e_wd = 1'b0; rel = 1'b0; g = m_owner;
    if (g >= 0) begin
      xfer  = req_valid[g] && !txf;
      e_rdy = txf ? '0 : (N'(1) << g);
      e_dat = req_data[g*W +: W];
      e_lt  = xfer && !req_last[g] && (m_beats == ML - 1);
`ifdef UART_ARB_WDOG_EN
      e_wd  = !req_valid[g] && !txf && (m_idle == TO - 1);
`endif
      chk("grant_id", {30'd0, grant_id}, g);
    end
    chk("busy", {31'd0, busy}, (g >= 0));
    chk("req_ready", {28'd0, req_ready}, {28'd0, e_rdy});
    chk("wr_uart", {31'd0, wr_uart}, {31'd0, xfer});
    chk("w_data", {24'd0, w_data}, {24'd0, e_dat});
    chk("len_trunc", {31'd0, len_trunc}, {31'd0, e_lt});
`ifdef UART_ARB_WDOG_EN
    chk("wdog_abort", {31'd0, wdog_abort}, {31'd0, e_wd});
    if (wdog_abort) wd_seen++;
`endif
    if (len_trunc) lt_seen++;
    if (wr_uart) begin
      lg_cyc.push_back(cyc); lg_req.push_back(int'(grant_id)); lg_dat.push_back(w_data);
    end
    @(posedge clk);
    cyc++;
    if (g < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && req_valid[(m_last + k) % N]) m_owner = (m_last + k) % N;
      end
      m_beats = 0; m_idle = 0;
    end else begin
      if (xfer) begin
        m_beats++;
        m_idle = 0;
        rel = req_last[g] || (m_beats == ML);
        void'(q[g].pop_front());
      end else if (!req_valid[g]) begin
        if (e_wd) rel = 1'b1;
        else if (!txf) m_idle++;
      end else begin
        m_idle = 0;
      end
      if (rel) begin
        m_last = g; m_owner = -1; m_beats = 0; m_idle = 0;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_wr"}, {31'd0, wr_uart}, 0);
    chk({tag, "_rdy"}, {28'd0, req_ready}, 0);
    chk({tag, "_wdata"}, {24'd0, w_data}, 0);
    chk({tag, "_gid"}, {30'd0, grant_id}, 0);
    chk({tag, "_lt"}, {31'd0, len_trunc}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int c0, left, budget;
    rst_n = 1'b1; en = '1; txf = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
    lt_seen = 0; wd_seen = 0;
    #1;
    do_reset();

    // Single requester, 3-byte packet
    clear_log(); c0 = cyc;
    push_pkt(1, 3, 8'hA1);
    run(6);
    chk("s1_n", lg_req.size(), 3);
    chk_ent("s1_b0", 0, c0 + 1, 1, 8'hA1);
    chk_ent("s1_b1", 1, c0 + 2, 1, 8'hA2);
    chk_ent("s1_b2", 2, c0 + 3, 1, 8'hA3);

    // Two simultaneous requesters from reset
    do_reset();
    clear_log(); c0 = cyc;
    push_pkt(0, 2, 8'hB0);
    push_pkt(2, 2, 8'hC0);
    run(8);
    chk("s2_n", lg_req.size(), 4);
    chk_ent("s2_b0", 0, c0 + 1, 0, 8'hB0);
    chk_ent("s2_b1", 1, c0 + 2, 0, 8'hB1);
    chk_ent("s2_b2", 2, c0 + 4, 2, 8'hC0);
    chk_ent("s2_b3", 3, c0 + 5, 2, 8'hC1);

    // tx_full stall mid-packet
    clear_log(); c0 = cyc;
    push_pkt(1, 4, 8'hD0);
    for (int i = 0; i < 12; i++) begin
      txf = (i >= 3 && i < 8);
      cycle();
    end
    txf = 1'b0;
    chk("s3_n", lg_req.size(), 4);
    chk_ent("s3_b1", 1, c0 + 2, 1, 8'hD1);
    chk_ent("s3_b2", 2, c0 + 8, 1, 8'hD2);
    chk_ent("s3_b3", 3, c0 + 9, 1, 8'hD3);

    // MAX_LEN cap with a competing requester
    clear_log(); c0 = cyc; lt_seen = 0;
    push_pkt(3, 20, 8'hE0);
    for (int i = 0; i < 28; i++) begin
      if (i == 3) push_pkt(0, 2, 8'hF0);
      cycle();
    end
    chk("s4_lt", lt_seen, 1);
    chk("s4_n", lg_req.size(), 22);
    chk_ent("s4_b15", 15, c0 + 16, 3, 8'hEF);
    chk_ent("s4_f0", 16, c0 + 18, 0, 8'hF0);
    chk_ent("s4_e16", 18, c0 + 21, 3, 8'hF0);
    chk_ent("s4_e19", 21, c0 + 24, 3, 8'hF3);

    // Reset after 2 of 5 beats
    clear_log();
    push_pkt(2, 5, 8'h60);
    run(3);
    chk("s5_pre", lg_req.size(), 2);
    drive();
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_pkt(0, 1, 8'h70);
    clear_log(); c0 = cyc;
    run(10);
    chk_ent("s5_first", 0, c0 + 1, 0, 8'h70);
    chk_ent("s5_rest", 1, c0 + 3, 2, 8'h62);

`ifdef UART_ARB_WDOG_EN
    // Silent owner released by watchdog
    wd_seen = 0; clear_log();
    push_pkt(1, 3, 8'h80);
    run(2);
    en[1] = 1'b0;
    push_pkt(2, 1, 8'h90);
    run(TO + 4);
    chk("wd_pulses", wd_seen, 1);
    chk_ent("wd_next", 1, -1, 2, 8'h90);
    en = '1;
    run(8);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (q[r].size() < 40) push_pkt(r, $urandom_range(1, 20), $urandom_range(0, 255));
      end
      for (int k = 0; k < N; k++) en[k] = ($urandom_range(0, 9) != 0);
      txf = ($urandom_range(0, 4) == 0);
      cycle();
    end
    en = '1; txf = 1'b0;
    budget = 0;
    left = 1;
    while (left != 0 && budget < 3000) begin
      cycle();
      budget++;
      left = 0;
      for (int k = 0; k < N; k++) left += q[k].size();
    end
    chk("drain_left", left, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
